// File: rtl/counter4.sv
// Parameterised binary up-counter with asynchronous active-high reset and
// a combinational terminal-count flag for control sequencing.
module counter4 #(
    parameter int          WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             c_up,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    // RST_VAL is truncated to the counter width.
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    // rst_b is active-high despite its suffix.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b)
            out <= RST_W;
        else if (c_up)
            out <= out + WIDTH'(1);
    end

    assign tc = &out;

endmodule

// File: tb/tb_counter4.sv
// Scoreboard bench for counter4: stimulus pushes hand-computed expectations,
// a monitor process pops and compares them against two DUT configurations.
module tb_counter4;

    logic       clk = 1'b0;
    logic       rst4 = 1'b0, cup4 = 1'b0;
    logic       rst8 = 1'b0, cup8 = 1'b0;
    logic [3:0] out4;
    logic       tc4;
    logic [7:0] out8;
    logic       tc8;

    always #5 clk = ~clk;

    counter4 dut4 (
        .clk  (clk),
        .rst_b(rst4),
        .c_up (cup4),
        .out  (out4),
        .tc   (tc4)
    );

    counter4 #(.WIDTH(8), .RST_VAL(250)) dut8 (
        .clk  (clk),
        .rst_b(rst8),
        .c_up (cup8),
        .out  (out8),
        .tc   (tc8)
    );

    typedef struct {
        bit         d8;
        logic [7:0] o;
        logic       t;
        string      nm;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: pops every queued expectation when the stimulus says the
    // outputs are ready to be observed.
    initial begin
        exp_t       e;
        logic [8:0] act;
        logic [8:0] req;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = e.d8 ? {out8, tc8} : {4'b0000, out4, tc4};
                req = {e.o, e.t};
                n_cmp++;
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL %s: got out=%0d tc=%b, want out=%0d tc=%b",
                             e.nm, act[8:1], act[0], req[8:1], req[0]);
                end
            end
        end
    end

    task automatic expect_now(input bit d8, input logic [7:0] o, input logic t,
                              input string nm);
        exp_t e;
        e.d8 = d8; e.o = o; e.t = t; e.nm = nm;
        q.push_back(e);
        -> sample_ev;
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic edge_expect(input bit d8, input logic [7:0] o, input logic t,
                               input string nm);
        @(posedge clk);
        #1;
        expect_now(d8, o, t, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        // Async reset at t=10 (a falling clock edge), c_up already high.
        cup4 = 1'b1;
        #10 rst4 = 1'b1;
        #1 expect_now(0, 8'd0, 1'b0, "async_rst");
        for (int i = 0; i < 3; i++) edge_expect(0, 8'd0, 1'b0, "rst_hold");
        rst4 = 1'b0;

        // Basic count: 1..5
        for (int i = 1; i <= 5; i++) edge_expect(0, 8'(i), 1'b0, "basic_count");

        // Wrap: reset between edges, 15 edges to all ones, then wrap to 0
        rst4 = 1'b1;
        #1 expect_now(0, 8'd0, 1'b0, "rst_before_wrap");
        #1 rst4 = 1'b0;
        for (int i = 1; i <= 14; i++) edge_expect(0, 8'(i), 1'b0, "wrap_count");
        edge_expect(0, 8'd15, 1'b1, "tc_at_15");
        edge_expect(0, 8'd0, 1'b0, "wrap_to_0");

        // Hold at 6
        for (int i = 1; i <= 6; i++) edge_expect(0, 8'(i), 1'b0, "to_6");
        cup4 = 1'b0;
        for (int i = 0; i < 3; i++) edge_expect(0, 8'd6, 1'b0, "hold_6");
        cup4 = 1'b1;
        edge_expect(0, 8'd7, 1'b0, "resume_7");

        // Reset mid-count at 10
        for (int i = 8; i <= 10; i++) edge_expect(0, 8'(i), 1'b0, "to_10");
        rst4 = 1'b1;
        #1 expect_now(0, 8'd0, 1'b0, "mid_rst_pulse");
        #2 rst4 = 1'b0;
        edge_expect(0, 8'd1, 1'b0, "after_mid_rst");

        // WIDTH=8, RST_VAL=250
        rst8 = 1'b1;
        #1 expect_now(1, 8'd250, 1'b0, "w8_rst");
        edge_expect(1, 8'd250, 1'b0, "w8_rst_hold");
        rst8 = 1'b0;
        cup8 = 1'b1;
        for (int i = 251; i <= 254; i++) edge_expect(1, 8'(i), 1'b0, "w8_count");
        edge_expect(1, 8'd255, 1'b1, "w8_tc");
        edge_expect(1, 8'd0, 1'b0, "w8_wrap");

        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
